// File: rtl/sd_card_cmd_responder.sv
// sd_card_cmd_responder: card-side endpoint of the SD CMD line.
// Oversamples the host sd_clk, receives 48-bit commands, hands them to a card
// model and serialises 48-bit responses with an automatically generated CRC7.
// Build option: define SD_CMD_CRC_CHECK_EN to check the CRC7 of received
// commands. When it is undefined, the received CRC is ignored and
// cmd_crc_err is tied low.
module sd_card_cmd_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NCR_MIN     = 2,
    parameter int unsigned NCR_MAX     = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sd_clk,
    input  logic        sd_cmd_in,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        cmd_crc_err,
    output logic        cmd_frame_err,
    output logic        rsp_ready,
    input  logic        rsp_valid,
    input  logic [5:0]  rsp_index,
    input  logic [31:0] rsp_payload
);

    localparam int unsigned FRAME_W = 48;
    localparam int unsigned CNT_W   = $clog2(NCR_MAX + NCR_MIN + 2) + 1;

    localparam logic [CNT_W-1:0] CNT_SAT      = '1;
    localparam logic [CNT_W-1:0] NCR_MIN_C    = CNT_W'(NCR_MIN);
    localparam logic [CNT_W-1:0] NCR_MAX_LAST = CNT_W'(NCR_MAX - 1);
    localparam logic [5:0]       LAST_RX_BIT  = 6'(FRAME_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_CHECK,
        S_WAIT_RSP,
        S_GAP,
        S_TX,
        S_REL
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] cmd_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   cmd_s;
    logic                   sd_rise;
    logic                   sd_fall;
    logic [FRAME_W-1:0]     rx_shift;
    logic [FRAME_W-1:0]     tx_shift;
    logic [5:0]             bit_cnt;
    logic [CNT_W-1:0]       rise_cnt;
    logic                   rel_fall;

    // CRC7, polynomial x^7 + x^3 + 1, init 0, MSB first over 40 bits
    function automatic logic [6:0] crc7_calc(input logic [39:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = '0;
        for (int i = 39; i >= 0; i--) begin
            fb  = data[i] ^ crc[6];
            crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return crc;
    endfunction

    // Synchronised views of the host clock and CMD line plus edge strobes
    assign clk_s   = clk_sync[SYNC_STAGES-1];
    assign cmd_s   = cmd_sync[SYNC_STAGES-1];
    assign sd_rise = clk_s & ~clk_prev;
    assign sd_fall = ~clk_s & clk_prev;

`ifdef SD_CMD_CRC_CHECK_EN
    logic [6:0] rx_crc_calc;

    // CRC7 recomputed over the received start..argument bits
    assign rx_crc_calc = crc7_calc(rx_shift[47:8]);
`else
    assign cmd_crc_err = 1'b0;
`endif

    // Input synchronisers, frame receive, response handshake and CMD drive
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            clk_sync      <= '0;
            cmd_sync      <= '1;
            clk_prev      <= 1'b0;
            rx_shift      <= '0;
            tx_shift      <= '1;
            bit_cnt       <= '0;
            rise_cnt      <= '0;
            rel_fall      <= 1'b0;
            sd_cmd_out    <= 1'b1;
            sd_cmd_oe     <= 1'b0;
            cmd_valid     <= 1'b0;
            cmd_index     <= '0;
            cmd_arg       <= '0;
            cmd_frame_err <= 1'b0;
            rsp_ready     <= 1'b0;
`ifdef SD_CMD_CRC_CHECK_EN
            cmd_crc_err   <= 1'b0;
`endif
        end else begin
            clk_sync      <= {clk_sync[SYNC_STAGES-2:0], sd_clk};
            cmd_sync      <= {cmd_sync[SYNC_STAGES-2:0], sd_cmd_in};
            clk_prev      <= clk_s;
            cmd_valid     <= 1'b0;
            cmd_frame_err <= 1'b0;
`ifdef SD_CMD_CRC_CHECK_EN
            cmd_crc_err   <= 1'b0;
`endif
            // Rises since the command end bit; cleared in CHECK, saturating
            if (sd_rise && (rise_cnt != CNT_SAT)) begin
                rise_cnt <= rise_cnt + CNT_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (sd_rise && !cmd_s) begin
                        rx_shift <= {rx_shift[FRAME_W-2:0], cmd_s};
                        bit_cnt  <= 6'd1;
                        state    <= S_RX;
                    end
                end

                S_RX: begin
                    if (sd_rise) begin
                        rx_shift <= {rx_shift[FRAME_W-2:0], cmd_s};
                        bit_cnt  <= bit_cnt + 6'd1;
                        if (bit_cnt == LAST_RX_BIT) begin
                            state <= S_CHECK;
                        end
                    end
                end

                S_CHECK: begin
                    rise_cnt <= '0;
                    if (rx_shift[47] || !rx_shift[46]) begin
                        // Not a host command (e.g. another card's response)
                        state <= S_IDLE;
                    end else if (!rx_shift[0]) begin
                        cmd_frame_err <= 1'b1;
                        state         <= S_IDLE;
`ifdef SD_CMD_CRC_CHECK_EN
                    end else if (rx_crc_calc != rx_shift[7:1]) begin
                        cmd_crc_err <= 1'b1;
                        state       <= S_IDLE;
`endif
                    end else begin
                        cmd_index <= rx_shift[45:40];
                        cmd_arg   <= rx_shift[39:8];
                        cmd_valid <= 1'b1;
                        rsp_ready <= 1'b1;
                        state     <= S_WAIT_RSP;
                    end
                end

                S_WAIT_RSP: begin
                    if (rsp_valid && rsp_ready) begin
                        tx_shift  <= {2'b00, rsp_index, rsp_payload,
                                      crc7_calc({2'b00, rsp_index, rsp_payload}),
                                      1'b1};
                        rsp_ready <= 1'b0;
                        state     <= S_GAP;
                    end else if (sd_rise && (rise_cnt >= NCR_MAX_LAST)) begin
                        // Card model never answered: drop the response silently
                        rsp_ready <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                S_GAP: begin
                    if (sd_fall && (rise_cnt >= NCR_MIN_C)) begin
                        sd_cmd_out <= tx_shift[FRAME_W-1];
                        sd_cmd_oe  <= 1'b1;
                        tx_shift   <= {tx_shift[FRAME_W-2:0], 1'b1};
                        bit_cnt    <= LAST_RX_BIT;
                        state      <= S_TX;
                    end
                end

                S_TX: begin
                    if (sd_fall) begin
                        sd_cmd_out <= tx_shift[FRAME_W-1];
                        tx_shift   <= {tx_shift[FRAME_W-2:0], 1'b1};
                        bit_cnt    <= bit_cnt - 6'd1;
                        if (bit_cnt == 6'd1) begin
                            rel_fall <= 1'b0;
                            state    <= S_REL;
                        end
                    end
                end

                S_REL: begin
                    // Hold the line high one extra period before releasing it
                    if (sd_fall) begin
                        sd_cmd_out <= 1'b1;
                        if (!rel_fall) begin
                            rel_fall <= 1'b1;
                        end else begin
                            sd_cmd_oe <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Testbench for sd_card_cmd_responder: host-side CMD driver, response sampler
// and a scoreboard of expected accepted commands.
`timescale 1ns/1ps
module tb_sd_card_cmd_responder;

    localparam int unsigned NCR_MIN = 2;
    localparam int unsigned NCR_MAX = 64;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sd_clk = 1'b0;
    logic        host_cmd = 1'b1;
    logic        sd_cmd_out;
    logic        sd_cmd_oe;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        cmd_crc_err;
    logic        cmd_frame_err;
    logic        rsp_ready;
    logic        rsp_valid = 1'b0;
    logic [5:0]  rsp_index = '0;
    logic [31:0] rsp_payload = '0;
    logic        cmd_line;

    int   vectors = 0;
    int   miscompares = 0;
    int   crc_err_cnt = 0;
    int   frame_err_cnt = 0;
    int   sd_half = 2;
    bit   oe_seen = 1'b0;
    bit   rdy_seen = 1'b0;
    cmd_t exp_q[$];
    cmd_t e_mon;

    // Open-drain style CMD line: host releases to 1, card drives when oe=1
    assign cmd_line = sd_cmd_oe ? sd_cmd_out : host_cmd;

    sd_card_cmd_responder #(
        .SYNC_STAGES(2),
        .NCR_MIN(NCR_MIN),
        .NCR_MAX(NCR_MAX)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sd_clk(sd_clk),
        .sd_cmd_in(cmd_line),
        .sd_cmd_out(sd_cmd_out),
        .sd_cmd_oe(sd_cmd_oe),
        .cmd_valid(cmd_valid),
        .cmd_index(cmd_index),
        .cmd_arg(cmd_arg),
        .cmd_crc_err(cmd_crc_err),
        .cmd_frame_err(cmd_frame_err),
        .rsp_ready(rsp_ready),
        .rsp_valid(rsp_valid),
        .rsp_index(rsp_index),
        .rsp_payload(rsp_payload)
    );

    always #5 clk = ~clk;

    // Host SD clock: half period of sd_half system clocks
    always begin
        repeat (sd_half) @(negedge clk);
        sd_clk = ~sd_clk;
    end

    // Event counters and command scoreboard
    always @(negedge clk) begin
        if (cmd_crc_err)   crc_err_cnt++;
        if (cmd_frame_err) frame_err_cnt++;
        if (sd_cmd_oe)     oe_seen = 1'b1;
        if (rsp_ready)     rdy_seen = 1'b1;
        if (cmd_valid) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL cmd_valid_unexpected: got idx=%0d arg=%h, required no command", cmd_index, cmd_arg);
            end else begin
                e_mon = exp_q.pop_front();
                if (cmd_index !== e_mon.idx || cmd_arg !== e_mon.arg) begin
                    miscompares++;
                    $display("FAIL cmd_decode: got idx=%0d arg=%h, required idx=%0d arg=%h", cmd_index, cmd_arg, e_mon.idx, e_mon.arg);
                end
            end
        end
    end

    // Reference CRC7 as polynomial long division of msg*x^7 by 0x89
    function automatic logic [6:0] crc7_model(input logic [39:0] msg);
        logic [46:0] r;
        r = {msg, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    task automatic wait_sd(input int n);
        repeat (n) @(negedge sd_clk);
    endtask

    // Host drives each bit on the falling sd_clk edge, then releases the line
    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            @(negedge sd_clk);
            host_cmd = f[i];
        end
        @(negedge sd_clk);
        host_cmd = 1'b1;
    endtask

    // Wait for a response start bit, sampling the line at each falling edge
    task automatic wait_rsp_start(output int falls, output bit found);
        found = 1'b0;
        falls = 0;
        for (int k = 1; k <= int'(NCR_MAX) + 8; k++) begin
            @(negedge sd_clk);
            if (!found && cmd_line === 1'b0) begin
                found = 1'b1;
                falls = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (sd_cmd_out !== 1'b1 || sd_cmd_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_cmd_drive: got out=%b oe=%b, required out=1 oe=0", sd_cmd_out, sd_cmd_oe);
        end
        vectors++;
        if (cmd_valid !== 1'b0 || cmd_crc_err !== 1'b0 || cmd_frame_err !== 1'b0 || rsp_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_strobes: got valid=%b crc=%b frame=%b rdy=%b, required all 0", cmd_valid, cmd_crc_err, cmd_frame_err, rsp_ready);
        end
        vectors++;
        if (cmd_index !== 6'd0 || cmd_arg !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_cmd_fields: got idx=%0d arg=%h, required 0 0", cmd_index, cmd_arg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_sd(4);
    endtask

    task automatic test_cmd0_no_rsp();
        oe_seen = 1'b0;
        rsp_valid = 1'b0;
        exp_q.push_back('{idx: 6'd0, arg: 32'd0});
        send_frame(48'h40_0000_0000_95);
        repeat (8) @(negedge clk);
        vectors++;
        if (rsp_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL cmd0_rsp_ready: got %b, required 1", rsp_ready);
        end
        wait_sd(NCR_MAX + 4);
        vectors++;
        if (rsp_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL cmd0_timeout_ready: got %b, required 0", rsp_ready);
        end
        vectors++;
        if (oe_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL cmd0_oe_never: got oe_seen=%b, required 0", oe_seen);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL cmd0_accepted: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_cmd8_rsp();
        logic [47:0] rsp;
        int          falls;
        bit          found;
        rsp = '1;
        rsp_index = 6'd8;
        rsp_payload = 32'h0000_01AA;
        rsp_valid = 1'b1;
        exp_q.push_back('{idx: 6'd8, arg: 32'h0000_01AA});
        send_frame(48'h48_0000_01AA_87);
        wait_rsp_start(falls, found);
        rsp_valid = 1'b0;
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL cmd8_rsp_start: got no start bit, required one within %0d sd_clk", NCR_MAX + 8);
        end else begin
            vectors++;
            if (falls - 1 < int'(NCR_MIN)) begin
                miscompares++;
                $display("FAIL cmd8_ncr_gap: got %0d idle periods, required >= %0d", falls - 1, NCR_MIN);
            end
            rsp[47] = 1'b0;
            for (int b = 46; b >= 0; b--) begin
                @(negedge sd_clk);
                rsp[b] = cmd_line;
            end
            vectors++;
            if (rsp[46] !== 1'b0 || rsp[45:40] !== 6'd8) begin
                miscompares++;
                $display("FAIL cmd8_rsp_index: got dir=%b idx=%0d, required dir=0 idx=8", rsp[46], rsp[45:40]);
            end
            vectors++;
            if (rsp[39:8] !== 32'h0000_01AA) begin
                miscompares++;
                $display("FAIL cmd8_rsp_payload: got %h, required 000001aa", rsp[39:8]);
            end
            vectors++;
            if (rsp[7:1] !== crc7_model(rsp[47:8])) begin
                miscompares++;
                $display("FAIL cmd8_rsp_crc: got %h, required %h", rsp[7:1], crc7_model(rsp[47:8]));
            end
            vectors++;
            if (rsp[0] !== 1'b1 || sd_cmd_oe !== 1'b1) begin
                miscompares++;
                $display("FAIL cmd8_rsp_end: got end=%b oe=%b, required end=1 oe=1", rsp[0], sd_cmd_oe);
            end
            @(negedge sd_clk);
            vectors++;
            if (sd_cmd_oe !== 1'b1 || sd_cmd_out !== 1'b1) begin
                miscompares++;
                $display("FAIL cmd8_rel_hold: got oe=%b out=%b, required oe=1 out=1", sd_cmd_oe, sd_cmd_out);
            end
            @(negedge sd_clk);
            vectors++;
            if (sd_cmd_oe !== 1'b0) begin
                miscompares++;
                $display("FAIL cmd8_release: got oe=%b, required 0", sd_cmd_oe);
            end
        end
        wait_sd(4);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL cmd8_accepted: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_crc_err();
        int crc0;
        crc0 = crc_err_cnt;
        rsp_valid = 1'b0;
`ifdef SD_CMD_CRC_CHECK_EN
        send_frame(48'h48_0000_01AA_89);
        wait_sd(NCR_MAX + 6);
        vectors++;
        if (crc_err_cnt - crc0 != 1) begin
            miscompares++;
            $display("FAIL crc_err_pulse: got %0d pulses, required 1", crc_err_cnt - crc0);
        end
`else
        exp_q.push_back('{idx: 6'd8, arg: 32'h0000_01AA});
        send_frame(48'h48_0000_01AA_89);
        wait_sd(NCR_MAX + 6);
        vectors++;
        if (crc_err_cnt - crc0 != 0 || cmd_crc_err !== 1'b0) begin
            miscompares++;
            $display("FAIL crc_err_tied: got %0d pulses, required 0", crc_err_cnt - crc0);
        end
`endif
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL crc_err_scoreboard: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_frame_err();
        int fe0;
        fe0 = frame_err_cnt;
        rsp_valid = 1'b0;
        rdy_seen = 1'b0;
        send_frame(48'h48_0000_01AA_86);
        wait_sd(8);
        vectors++;
        if (frame_err_cnt - fe0 != 1) begin
            miscompares++;
            $display("FAIL frame_err_pulse: got %0d pulses, required 1", frame_err_cnt - fe0);
        end
        vectors++;
        if (rdy_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_err_ready: got rdy_seen=%b, required 0", rdy_seen);
        end
    endtask

    task automatic test_reset_mid_tx();
        int falls;
        bit found;
        rsp_index = 6'd3;
        rsp_payload = 32'hDEAD_BEEF;
        rsp_valid = 1'b1;
        exp_q.push_back('{idx: 6'd8, arg: 32'h0000_01AA});
        send_frame(48'h48_0000_01AA_87);
        wait_rsp_start(falls, found);
        rsp_valid = 1'b0;
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL rst_tx_start: got no start bit, required one");
        end
        // Start bit was sampled; move on until bit 20 is on the line
        wait_sd(47 - 20 - 1);
        repeat (4) @(negedge clk);
        vectors++;
        if (sd_cmd_oe !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_tx_driving: got oe=%b, required 1", sd_cmd_oe);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (sd_cmd_oe !== 1'b0 || sd_cmd_out !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_tx_release: got oe=%b out=%b, required oe=0 out=1", sd_cmd_oe, sd_cmd_out);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_sd(4);
        exp_q.push_back('{idx: 6'd0, arg: 32'd0});
        send_frame(48'h40_0000_0000_95);
        wait_sd(NCR_MAX + 6);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rst_tx_cmd0_after: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] other;
        int          half_tab[2];
        int          crc0;
        int          fe0;
        half_tab[0] = 2;
        half_tab[1] = 5;
        other = {8'h08, 32'h0000_01AA, crc7_model({8'h08, 32'h0000_01AA}), 1'b1};
        rsp_valid = 1'b0;
        for (int h = 0; h < 2; h++) begin
            sd_half = half_tab[h];
            wait_sd(4);
            crc0 = crc_err_cnt;
            fe0 = frame_err_cnt;
            oe_seen = 1'b0;
            send_frame(other);
            exp_q.push_back('{idx: 6'd0, arg: 32'd0});
            send_frame(48'h40_0000_0000_95);
            wait_sd(NCR_MAX + 6);
            vectors++;
            if (exp_q.size() != 0) begin
                miscompares++;
                $display("FAIL b2b_cmd0_half%0d: got %0d pending, required 0", sd_half, exp_q.size());
            end
            vectors++;
            if (crc_err_cnt != crc0 || frame_err_cnt != fe0 || oe_seen) begin
                miscompares++;
                $display("FAIL b2b_silent_half%0d: got crc=%0d frame=%0d oe_seen=%b, required 0 0 0", sd_half, crc_err_cnt - crc0, frame_err_cnt - fe0, oe_seen);
            end
        end
        sd_half = 2;
    endtask

    initial begin
        test_reset();
        test_cmd0_no_rsp();
        test_cmd8_rsp();
        test_crc_err();
        test_frame_err();
        test_reset_mid_tx();
        test_back_to_back();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global bound on simulation time
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
